// File: rtl/delta_frame_sched.sv
// Frame-level scheduler for the delta-frame motion datapath.
// Sequences base-frame capture, filter settling and delta operation on frame
// boundaries, forces periodic or requested base refreshes, and double-buffers
// the saturation threshold so it only changes between frames.
module delta_frame_sched #(
  parameter int INPUT_WIDTH    = 10,
  parameter int H_ACTIVE       = 640,
  parameter int V_ACTIVE       = 480,
  parameter int REFRESH_FRAMES = 30,
  parameter int SETTLE_FRAMES  = 2,
  parameter int THRESH_INIT    = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   recapture,
  input  logic                   frame_start,
  input  logic                   is_not_blank,
  input  logic [INPUT_WIDTH-1:0] threshold_in,
  input  logic                   threshold_wr,
  output logic [INPUT_WIDTH-1:0] threshold,
  output logic                   base_wr_en,
  output logic                   delta_en,
  output logic [2:0]             state,
  output logic [15:0]            frame_count,
  output logic                   capture_done,
  output logic                   frame_err
);

  localparam int PIX_TOTAL = H_ACTIVE * V_ACTIVE;
  localparam int PW        = $clog2(PIX_TOTAL + 1);
  localparam logic [PW-1:0] PIX_FULL = PW'(PIX_TOTAL);
  localparam logic [PW-1:0] PIX_MAX  = '1;

  // Settle counter runs 0 .. SETTLE_FRAMES-1; keep it at least one bit wide
  // so the design still elaborates when settling is disabled.
  localparam int SW = (SETTLE_FRAMES > 1) ? $clog2(SETTLE_FRAMES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST =
    SW'((SETTLE_FRAMES > 0) ? SETTLE_FRAMES - 1 : 0);

  localparam logic [15:0] REFRESH_CNT = 16'(REFRESH_FRAMES);
  localparam logic [INPUT_WIDTH-1:0] THRESH_RST = INPUT_WIDTH'(THRESH_INIT);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_CAPTURE = 3'd2,
    S_SETTLE  = 3'd3,
    S_RUN     = 3'd4
  } state_t;

  state_t                 state_q,   state_d;
  logic                   pend_q,    pend_d;
  logic [SW-1:0]          settle_q,  settle_d;
  logic [15:0]            fc_q,      fc_d;
  logic                   err_q,     err_d;
  logic                   done_q,    done_d;
  logic [PW-1:0]          pix_q,     pix_d;
  logic [INPUT_WIDTH-1:0] shadow_q,  shadow_d;
  logic [INPUT_WIDTH-1:0] thr_q,     thr_d;
  logic [15:0]            fc_inc;

  // Next-state logic: stop beats frame boundary decisions, which beat start/recapture.
  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    settle_d = settle_q;
    fc_d     = fc_q;
    err_d    = err_q;
    done_d   = 1'b0;
    fc_inc   = (fc_q == 16'hFFFF) ? fc_q : fc_q + 16'd1;

    if (stop) begin
      state_d  = S_IDLE;
      pend_d   = 1'b0;
      settle_d = '0;
    end else begin
      if (recapture && (state_q != S_IDLE)) begin
        pend_d = 1'b1;
      end
      if (frame_start) begin
        case (state_q)
          S_ARM: state_d = S_CAPTURE;
          S_CAPTURE: begin
            if (pix_q == PIX_FULL) begin
              done_d   = 1'b1;
              fc_d     = '0;
              pend_d   = 1'b0;
              settle_d = '0;
              state_d  = (SETTLE_FRAMES == 0) ? S_RUN : S_SETTLE;
            end else begin
              // Short or long capture frame: flag it and retry on the next frame.
              err_d = 1'b1;
            end
          end
          S_SETTLE: begin
            if (settle_q == SETTLE_LAST) begin
              settle_d = '0;
              state_d  = S_RUN;
            end else begin
              settle_d = settle_q + 1'b1;
            end
          end
          S_RUN: begin
            if (pix_q != PIX_FULL) begin
              err_d = 1'b1;
            end
            fc_d = fc_inc;
            // A recapture arriving on this very boundary waits for the next one.
            if (pend_q || ((REFRESH_FRAMES != 0) && (fc_inc == REFRESH_CNT))) begin
              state_d = S_CAPTURE;
            end
          end
          default: ;
        endcase
      end
      if (start && (state_q == S_IDLE)) begin
        state_d = S_ARM;
        err_d   = 1'b0;
      end
    end
  end

  // Active-pixel counter, sampled then cleared on each frame boundary.
  always_comb begin
    pix_d = pix_q;
    if (frame_start) begin
      pix_d = '0;
    end else if (is_not_blank && (pix_q != PIX_MAX)) begin
      pix_d = pix_q + 1'b1;
    end
  end

  // Threshold double buffer: applied at frame boundaries, or directly while idle.
  always_comb begin
    shadow_d = threshold_wr ? threshold_in : shadow_q;
    thr_d    = thr_q;
    if (frame_start) begin
      thr_d = shadow_q;
    end else if (threshold_wr && (state_q == S_IDLE)) begin
      thr_d = threshold_in;
    end
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pend_q   <= 1'b0;
      settle_q <= '0;
      fc_q     <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      pix_q    <= '0;
      shadow_q <= THRESH_RST;
      thr_q    <= THRESH_RST;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      settle_q <= settle_d;
      fc_q     <= fc_d;
      err_q    <= err_d;
      done_q   <= done_d;
      pix_q    <= pix_d;
      shadow_q <= shadow_d;
      thr_q    <= thr_d;
    end
  end

  // Pixel-rate enables are pure decode so they line up with the pixel itself.
  assign base_wr_en   = (state_q == S_CAPTURE) && is_not_blank;
  assign delta_en     = (state_q == S_RUN) && is_not_blank;
  assign state        = state_q;
  assign frame_count  = fc_q;
  assign capture_done = done_q;
  assign frame_err    = err_q;
  assign threshold    = thr_q;

endmodule

// File: tb/tb_delta_frame_sched.sv
// Directed testbench for delta_frame_sched using a tiny 4x2 frame.
module tb_delta_frame_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, stop, recapture, frame_start, is_not_blank;
  logic [9:0] threshold_in;
  logic       threshold_wr;
  logic [9:0] threshold;
  logic       base_wr_en, delta_en;
  logic [2:0] state;
  logic [15:0] frame_count;
  logic       capture_done, frame_err;

  int checks   = 0;
  int failures = 0;
  int base_cnt, delta_cnt;

  localparam int ST_IDLE = 0, ST_ARM = 1, ST_CAP = 2, ST_SET = 3, ST_RUN = 4;

  delta_frame_sched #(
    .INPUT_WIDTH(10), .H_ACTIVE(4), .V_ACTIVE(2),
    .REFRESH_FRAMES(3), .SETTLE_FRAMES(2), .THRESH_INIT(64)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .recapture(recapture),
    .frame_start(frame_start), .is_not_blank(is_not_blank),
    .threshold_in(threshold_in), .threshold_wr(threshold_wr),
    .threshold(threshold), .base_wr_en(base_wr_en), .delta_en(delta_en),
    .state(state), .frame_count(frame_count), .capture_done(capture_done),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fs_pulse();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  // Blank cycle, n active pixels (tallying the enables), blank cycle.
  task automatic pixels(input int n);
    base_cnt  = 0;
    delta_cnt = 0;
    step();
    for (int i = 0; i < n; i++) begin
      is_not_blank = 1'b1;
      #1;
      base_cnt  += int'(base_wr_en);
      delta_cnt += int'(delta_en);
      step();
    end
    is_not_blank = 1'b0;
    step();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 0; stop = 0; recapture = 0; frame_start = 0;
    is_not_blank = 0; threshold_in = '0; threshold_wr = 0;
    step(); step();
    reset = 1'b0;
    is_not_blank = 1'b1; #1;
    check("rst_state", 32'(state), ST_IDLE);
    check("rst_threshold", 32'(threshold), 64);
    check("rst_frame_count", 32'(frame_count), 0);
    check("rst_frame_err", 32'(frame_err), 0);
    check("rst_capture_done", 32'(capture_done), 0);
    check("rst_base_wr_en", 32'(base_wr_en), 0);
    check("rst_delta_en", 32'(delta_en), 0);
    is_not_blank = 1'b0;
    step();

    // Clean capture
    pulse_start();
    check("arm_state", 32'(state), ST_ARM);
    pixels(3);
    check("arm_no_base_wr", 32'(base_cnt), 0);
    check("arm_waits", 32'(state), ST_ARM);
    fs_pulse();
    check("capture_state", 32'(state), ST_CAP);
    pixels(8);
    check("capture_base_wr_cnt", 32'(base_cnt), 8);
    fs_pulse();
    check("capture_done_pulse", 32'(capture_done), 1);
    check("settle_state", 32'(state), ST_SET);
    step();
    check("capture_done_one_cycle", 32'(capture_done), 0);
    pixels(8);
    check("settle1_delta_cnt", 32'(delta_cnt), 0);
    fs_pulse();
    check("settle_still", 32'(state), ST_SET);
    pixels(8);
    check("settle2_delta_cnt", 32'(delta_cnt), 0);
    fs_pulse();
    check("run_state", 32'(state), ST_RUN);
    check("run_frame_count0", 32'(frame_count), 0);

    // Periodic refresh, with a mid-frame threshold update on the first frame
    pixels(4);
    threshold_in = 10'd200; threshold_wr = 1'b1;
    step();
    threshold_wr = 1'b0;
    check("thr_held_midframe", 32'(threshold), 64);
    pixels(4);
    check("run_delta_cnt", 32'(delta_cnt), 4);
    fs_pulse();
    check("thr_applied_at_frame", 32'(threshold), 200);
    check("fc_1", 32'(frame_count), 1);
    check("run_after_1", 32'(state), ST_RUN);
    pixels(8);
    fs_pulse();
    check("fc_2", 32'(frame_count), 2);
    pixels(8);
    fs_pulse();
    check("fc_3", 32'(frame_count), 3);
    check("refresh_to_capture", 32'(state), ST_CAP);
    check("no_err_so_far", 32'(frame_err), 0);

    // Short capture frame then good retry
    pixels(7);
    fs_pulse();
    check("short_frame_err", 32'(frame_err), 1);
    check("short_stays_capture", 32'(state), ST_CAP);
    check("short_no_done", 32'(capture_done), 0);
    pixels(8);
    fs_pulse();
    check("retry_done", 32'(capture_done), 1);
    check("retry_settle", 32'(state), ST_SET);
    check("retry_fc_cleared", 32'(frame_count), 0);
    pixels(8); fs_pulse();
    pixels(8); fs_pulse();
    check("run_again", 32'(state), ST_RUN);

    // Recapture mid-frame, then stop on a frame boundary
    pixels(4);
    recapture = 1'b1; step(); recapture = 0;
    pixels(4);
    fs_pulse();
    check("recap_to_capture", 32'(state), ST_CAP);
    check("recap_fc", 32'(frame_count), 1);
    check("err_sticky", 32'(frame_err), 1);
    pixels(8);
    stop = 1'b1; frame_start = 1'b1;
    step();
    stop = 1'b0; frame_start = 1'b0;
    check("stop_idle", 32'(state), ST_IDLE);
    check("stop_no_done", 32'(capture_done), 0);
    check("stop_fc_hold", 32'(frame_count), 1);
    is_not_blank = 1'b1; #1;
    check("stop_base_wr_off", 32'(base_wr_en), 0);
    is_not_blank = 1'b0;

    // Threshold writes in IDLE
    threshold_in = 10'd100; threshold_wr = 1'b1;
    step();
    threshold_wr = 1'b0;
    check("idle_thr_write", 32'(threshold), 100);
    threshold_in = 10'd300; threshold_wr = 1'b1; frame_start = 1'b1;
    step();
    threshold_wr = 1'b0; frame_start = 1'b0;
    check("thr_wr_on_fs_deferred", 32'(threshold), 100);
    step();
    fs_pulse();
    check("thr_wr_on_fs_applied", 32'(threshold), 300);

    // Restart clears frame_err; reset mid-CAPTURE
    pulse_start();
    check("start_clears_err", 32'(frame_err), 0);
    fs_pulse();
    check("cap_before_reset", 32'(state), ST_CAP);
    recapture = 1'b1; step(); recapture = 0;
    pixels(3);
    reset = 1'b1; is_not_blank = 1'b1;
    step();
    check("rst2_state", 32'(state), ST_IDLE);
    check("rst2_threshold", 32'(threshold), 64);
    check("rst2_frame_count", 32'(frame_count), 0);
    check("rst2_base_wr_en", 32'(base_wr_en), 0);
    reset = 1'b0; is_not_blank = 1'b0;
    step();

    // Short frame in RUN sets frame_err
    pulse_start();
    fs_pulse();
    pixels(8); fs_pulse();
    check("rst2_capture_done", 32'(capture_done), 1);
    pixels(8); fs_pulse();
    pixels(8); fs_pulse();
    check("run3_state", 32'(state), ST_RUN);
    pixels(5);
    fs_pulse();
    check("run_short_err", 32'(frame_err), 1);
    check("run_short_fc", 32'(frame_count), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/delta_frame_sched.md
# delta_frame_sched

Frame-level scheduler for the delta-frame motion datapath. Sequences base-frame capture, filter settling, and delta operation on video frame boundaries. Forces periodic or on-demand base-frame refresh and double-buffers the saturation threshold so it changes only between frames. Sits between the VGA/decoder timing logic and the delta datapath and base-frame buffer write port.

## Interface
- INPUT_WIDTH, 10, width of threshold value
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- REFRESH_FRAMES, 30, RUN frames between automatic base refreshes; 0 = never
- SETTLE_FRAMES, 2, frames discarded after a capture to flush the moving-average filter; 0 allowed
- THRESH_INIT, 64, threshold reset value

- clk  in  1  system clock; sole clock domain
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse: begin operation
- stop  in  1  one-cycle pulse: return to IDLE
- recapture  in  1  one-cycle pulse: request base refresh
- frame_start  in  1  one-cycle pulse in vertical blank, before first active pixel
- is_not_blank  in  1  high on each active pixel cycle
- threshold_in  in  INPUT_WIDTH  new threshold value
- threshold_wr  in  1  latch threshold_in into shadow register
- threshold  out  INPUT_WIDTH  threshold applied to delta datapath
- base_wr_en  out  1  write current pixel into base-frame buffer
- delta_en  out  1  delta result valid for downstream use
- state  out  3  current state encoding
- frame_count  out  16  RUN frames since last capture, saturating
- capture_done  out  1  one-cycle pulse on successful capture
- frame_err  out  1  sticky: a frame had pixel count ≠ H_ACTIVE*V_ACTIVE

## Operation
- States, encoded as `state`: IDLE=0, ARM=1, CAPTURE=2, SETTLE=3, RUN=4.
- IDLE: `start` goes to ARM and clears `frame_err`.
- ARM: waits for `frame_start`, then goes to CAPTURE. A capture never begins mid-frame.
- CAPTURE: `base_wr_en = is_not_blank`. At the next `frame_start`:
  - If `pix_cnt == H_ACTIVE*V_ACTIVE`: pulse `capture_done`, clear `frame_count` and the recapture-pending flag, then go to SETTLE, or to RUN if SETTLE_FRAMES=0.
  - Otherwise: set `frame_err` and stay in CAPTURE for a retry.
- SETTLE: counts `frame_start` pulses. On the SETTLE_FRAMES-th pulse, go to RUN. `delta_en` stays 0.
- RUN: `delta_en = is_not_blank`. At each `frame_start`:
  - If the pixel count is wrong, set `frame_err`.
  - Increment `frame_count`, saturating at 0xFFFF.
  - If the recapture flag is pending, or REFRESH_FRAMES≠0 and the incremented count equals REFRESH_FRAMES, go to CAPTURE.
- `recapture` sets the pending flag in ARM, CAPTURE, SETTLE or RUN. It is ignored in IDLE.
- Pixel counter `pix_cnt`:
  - Width is $clog2(H_ACTIVE*V_ACTIVE+1).
  - Increments on `is_not_blank` and saturates at its maximum.
  - Cleared on the `frame_start` cycle, after being sampled for that cycle's decision.
- Threshold:
  - `threshold_wr` loads the shadow register.
  - The shadow is copied to `threshold` on any `frame_start`.
  - In IDLE the copy happens on the cycle after `threshold_wr`.
  - `threshold_wr` coinciding with `frame_start`: the new value goes to the shadow only and is applied at the following `frame_start`.
- Priority: `reset` > `stop` > `frame_start` transition > `start`/`recapture`.
  - `stop` in any state goes to IDLE and clears the pending flag and settle counter. `frame_count` and `frame_err` hold.
  - `start` outside IDLE is ignored.
- Reset values: `state`=IDLE, `threshold`=shadow=THRESH_INIT, `frame_count`=0, `frame_err`=0, `capture_done`=0, `base_wr_en`=0, `delta_en`=0, `pix_cnt`=0, pending flag=0.

## Timing
- All state, counters, `threshold`, `frame_count`, `frame_err` and `capture_done` are registered.
- A transition decided on the `frame_start` cycle takes effect the next cycle. `capture_done` is high for exactly that next cycle.
- `base_wr_en` and `delta_en` are combinational: registered state decode AND `is_not_blank`. Zero latency to the pixel.
- The datapath's one-cycle absolute-difference register and its divider latency are absorbed downstream. The scheduler adds no pipeline delay.
- `frame_count` updates on the cycle after `frame_start`.

## Test plan
- **Clean capture:** H=4, V=2, SETTLE=2, REFRESH=3; `start`, then frames of 8 active pixels. Required:
  - ARM until first `frame_start`.
  - CAPTURE asserts `base_wr_en` on 8 pixels.
  - `capture_done` pulses once.
  - SETTLE spans 2 frames with `delta_en`=0, then RUN.
- **Periodic refresh:** same config in RUN. After 3 `frame_start` pulses, `frame_count`=3 and state returns to CAPTURE. `frame_count` is 0 after the next `capture_done`.
- **Short capture frame:** 7 active pixels during CAPTURE → `frame_err`=1, state stays CAPTURE. The next 8-pixel frame → `capture_done`, SETTLE.
- **Recapture plus stop:** `recapture` mid-frame in RUN → CAPTURE after the next `frame_start`. `stop` on the same cycle as a `frame_start` → IDLE, `base_wr_en`=0.
- **Threshold update:** `threshold_wr` with value 200 mid-frame in RUN → `threshold` stays 64 until the cycle after `frame_start`, then 200. A write in IDLE appears on the next cycle.
- **Reset mid-CAPTURE:** assert `reset` → all outputs at reset values on the next cycle, `threshold`=64, pending flag cleared.
